// File: rtl/conv2_rd_pkg.sv
// ---------------------------------------------------------------------------
// conv2_rd_pkg
// Shared types and constants for the conv2 output-memory read streamer.
//   rd_state_t : streamer control states
//   rd_tag_t   : per-word side-band flags carried alongside the data
//   win_addr() : pixel address of one element of a 2x2 pooling window
// ---------------------------------------------------------------------------
package conv2_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    localparam int IMG_W   = 8;
    localparam int N_CH    = 3;
    localparam int N_PIX   = 64;
    localparam int N_WORDS = 192;

    typedef struct packed {
        logic last_win;
        logic last;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

    // (2*wr+dy)*8 + 2*wc+dx with dy=e[1], dx=e[0]: every term lands on its
    // own bit field, so the address is a plain concatenation.
    function automatic logic [5:0] win_addr(input logic [1:0] wr,
                                            input logic [1:0] wc,
                                            input logic [1:0] e);
        return {wr, e[1], wc, e[0]};
    endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// rd_skid_fifo
// Small synchronous FIFO holding {tag, data} words returned from memory.
// The head entry is presented combinationally on pop_data so the consumer
// sees the word in the same cycle it becomes valid.
//   clk, reset       : clock, asynchronous active-high reset
//   push, push_data  : write request and word
//   pop              : remove head entry (ignored when empty)
//   pop_data         : current head entry
//   count            : number of stored entries
//   empty, full      : occupancy flags
// Push and pop in the same cycle are both honoured, including when full.
// ---------------------------------------------------------------------------
module rd_skid_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_reg != '0);
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (do_pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        if (do_push && !do_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/conv2_mem_read.sv
// ---------------------------------------------------------------------------
// conv2_mem_read
// Walks the three 8x8 conv2 output maps in 2x2 pooling-window order, issues
// memory reads, absorbs the fixed read latency and streams the words out
// over valid/ready without losing any under backpressure.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle run request (honoured in IDLE or DONE only)
//   mem_rd         : read enable; mem_ch / mem_addr select the pixel
//   mem_rdata      : read data, valid RD_LAT cycles after mem_rd
//   out_data       : FIFO head word; out_valid / out_ready handshake
//   out_last_win   : head word is element 3 of its 2x2 window
//   out_last       : head word is the final word of the run
//   busy           : RUN or DRAIN
//   done           : DONE
// Reads are credit-limited: reads in flight plus buffered words never
// exceed FIFO_DEPTH, so the buffer cannot overflow.
// ---------------------------------------------------------------------------
module conv2_mem_read
    import conv2_rd_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd,
    output logic [1:0]        mem_ch,
    output logic [5:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last_win,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = FCNT_W + 1;
    localparam int ENT_W  = TAG_W + DATA_W;

    rd_state_t         state_reg, state_next;
    logic [1:0]        ch_reg, ch_next;
    logic [1:0]        wr_reg, wr_next;
    logic [1:0]        wc_reg, wc_next;
    logic [1:0]        e_reg, e_next;

    logic [RD_LAT-1:0] pipe_valid_reg, pipe_valid_next;
    rd_tag_t           pipe_tag_reg  [RD_LAT];
    rd_tag_t           pipe_tag_next [RD_LAT];
    rd_tag_t           issue_tag;
    rd_tag_t           head_tag;

    logic              final_read;
    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  occupancy;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FCNT_W-1:0] fifo_count;
    logic [ENT_W-1:0]  fifo_head;

    // Counters currently point at ch 2, window 15, element 3.
    assign final_read = (ch_reg == 2'(N_CH - 1)) && (wr_reg == 2'd3) &&
                        (wc_reg == 2'd3) && (e_reg == 2'd3);

    assign issue_tag.last_win = (e_reg == 2'd3);
    assign issue_tag.last     = final_read;

    assign mem_ch   = ch_reg;
    assign mem_addr = win_addr(wr_reg, wc_reg, e_reg);

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // In-flight reads are exactly the set bits of the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SUM_W'(pipe_valid_reg[i]);
        end
    end

    // Occupancy after this cycle's pop; a push this cycle only moves a word
    // from the pipe into the FIFO and leaves the sum unchanged.
    assign occupancy = inflight + SUM_W'(fifo_count) - SUM_W'(fifo_pop);

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        wr_next    = wr_reg;
        wc_next    = wc_reg;
        e_next     = e_reg;
        mem_rd     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    ch_next    = '0;
                    wr_next    = '0;
                    wc_next    = '0;
                    e_next     = '0;
                end
            end
            ST_RUN: begin
                // The full term is already implied by the credit sum; it keeps
                // the no-overflow guarantee visible at the issue point.
                if ((occupancy < SUM_W'(FIFO_DEPTH)) && !(fifo_full && !fifo_pop)) begin
                    mem_rd = 1'b1;
                    e_next = e_reg + 2'd1;
                    if (e_reg == 2'd3) begin
                        wc_next = wc_reg + 2'd1;
                        if (wc_reg == 2'd3) begin
                            wr_next = wr_reg + 2'd1;
                            // Channel saturates at the last map instead of wrapping.
                            if ((wr_reg == 2'd3) && (ch_reg != 2'(N_CH - 1))) begin
                                ch_next = ch_reg + 2'd1;
                            end
                        end
                    end
                    if (final_read) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Using the post-pop count lets done rise in the cycle right
                // after the final word is accepted.
                if ((inflight == '0) && (occupancy == '0)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latency pipe: stage 0 captures the issue, the last stage feeds the FIFO
    // on the edge where mem_rdata is valid.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_valid_next[gi] = mem_rd;
                assign pipe_tag_next[gi]   = issue_tag;
            end else begin : g_tail
                assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
                assign pipe_tag_next[gi]   = pipe_tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ch_reg         <= '0;
            wr_reg         <= '0;
            wc_reg         <= '0;
            e_reg          <= '0;
            pipe_valid_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_tag_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            ch_reg         <= ch_next;
            wr_reg         <= wr_next;
            wc_reg         <= wc_next;
            e_reg          <= e_next;
            pipe_valid_reg <= pipe_valid_next;
            pipe_tag_reg   <= pipe_tag_next;
        end
    end

    assign fifo_push = pipe_valid_reg[RD_LAT-1];

    rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({pipe_tag_reg[RD_LAT-1], mem_rdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_tag     = rd_tag_t'(fifo_head[ENT_W-1:DATA_W]);
    assign out_data     = fifo_head[DATA_W-1:0];
    assign out_last_win = out_valid && head_tag.last_win;
    assign out_last     = out_valid && head_tag.last;

    assign busy = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_conv2_mem_read.sv
// ---------------------------------------------------------------------------
// tb_conv2_mem_read
// Two instances (RD_LAT=1, FIFO_DEPTH=3 and RD_LAT=3, FIFO_DEPTH=5) share
// clock, reset, start and out_ready; sel picks which one is observed.
// Memory model returns {ch, addr} for each read after RD_LAT cycles.
// Expected words are queued at start and popped on each accepted output.
// ---------------------------------------------------------------------------
module tb_conv2_mem_read;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, out_ready;

    logic        mem_rd_a, out_valid_a, out_last_win_a, out_last_a, busy_a, done_a;
    logic [1:0]  mem_ch_a;
    logic [5:0]  mem_addr_a;
    logic [15:0] mem_rdata_a, out_data_a;

    logic        mem_rd_b, out_valid_b, out_last_win_b, out_last_b, busy_b, done_b;
    logic [1:0]  mem_ch_b;
    logic [5:0]  mem_addr_b;
    logic [15:0] mem_rdata_b, out_data_b;

    conv2_mem_read #(.DATA_W(16), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd(mem_rd_a), .mem_ch(mem_ch_a), .mem_addr(mem_addr_a),
        .mem_rdata(mem_rdata_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last_win(out_last_win_a), .out_last(out_last_a),
        .busy(busy_a), .done(done_a)
    );

    conv2_mem_read #(.DATA_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd(mem_rd_b), .mem_ch(mem_ch_b), .mem_addr(mem_addr_b),
        .mem_rdata(mem_rdata_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last_win(out_last_win_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b)
    );

    // Memory models: garbage when no read was issued.
    logic [15:0] pa0, pb0, pb1, pb2;
    always @(posedge clk) begin
        pa0 <= mem_rd_a ? {8'h00, mem_ch_a, mem_addr_a} : 16'hDEAD;
        pb0 <= mem_rd_b ? {8'h00, mem_ch_b, mem_addr_b} : 16'hDEAD;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign mem_rdata_a = pa0;
    assign mem_rdata_b = pb2;

    logic        sel;
    logic        o_rd, o_valid, o_lw, o_last, o_busy, o_done;
    logic [1:0]  o_ch;
    logic [5:0]  o_addr;
    logic [15:0] o_data;

    always_comb begin
        o_rd = mem_rd_a; o_ch = mem_ch_a; o_addr = mem_addr_a; o_data = out_data_a;
        o_valid = out_valid_a; o_lw = out_last_win_a; o_last = out_last_a;
        o_busy = busy_a; o_done = done_a;
        if (sel) begin
            o_rd = mem_rd_b; o_ch = mem_ch_b; o_addr = mem_addr_b; o_data = out_data_b;
            o_valid = out_valid_b; o_lw = out_last_win_b; o_last = out_last_b;
            o_busy = busy_b; o_done = done_b;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];
    int addr_log[$];
    int issued, accepted, cycle_no, first_valid_cycle, last_pop_cycle, max_out, valid_seen;
    logic s_done, s_busy;

    // Expected {last_win, last, data} of word i in traversal order.
    function automatic logic [17:0] exp_word(input int i);
        int ch, r, wr, wc, e, addr;
        ch   = i / 64;
        r    = i % 64;
        wr   = r / 16;
        wc   = (r / 4) % 4;
        e    = r % 4;
        addr = (2 * wr + e / 2) * 8 + 2 * wc + e % 2;
        return {(e == 3), (i == 191), 16'(ch * 64 + addr)};
    endfunction

    // One clock: sample at negedge, consume accepted words, return at posedge+1.
    task automatic tick();
        logic [17:0] e;
        @(negedge clk);
        cycle_no++;
        s_done = o_done;
        s_busy = o_busy;
        if (o_rd) begin
            issued++;
            addr_log.push_back(int'(o_addr));
        end
        if (o_valid) begin
            valid_seen++;
            if (first_valid_cycle < 0) first_valid_cycle = cycle_no;
        end
        if (o_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_word extra word: got %h, required none", {o_lw, o_last, o_data});
            end else begin
                e = exp_q.pop_front();
                if ({o_lw, o_last, o_data} !== e) begin
                    failures++;
                    $display("FAIL sb_word %0d: got %h, required %h", accepted, {o_lw, o_last, o_data}, e);
                end
            end
            accepted++;
            last_pop_cycle = cycle_no;
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_run();
        exp_q.delete();
        addr_log.delete();
        issued = 0; accepted = 0; first_valid_cycle = -1; last_pop_cycle = -1;
        max_out = 0; valid_seen = 0;
    endtask

    task automatic pulse_start();
        clear_run();
        for (int i = 0; i < 192; i++) exp_q.push_back(exp_word(i));
        cycle_no = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_to_end(input int budget, input bit rnd);
        int n;
        n = 0;
        while (accepted < 192 && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; out_ready = 1'b1; reset = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd_a, mem_ch_a, mem_addr_a, out_valid_a, out_last_win_a, out_last_a, busy_a, done_a} !== 14'd0) begin
            failures++;
            $display("FAIL reset_a outputs: got %b, required 0", {mem_rd_a, mem_ch_a, mem_addr_a, out_valid_a, out_last_win_a, out_last_a, busy_a, done_a});
        end
        checks++;
        if ({mem_rd_b, mem_ch_b, mem_addr_b, out_valid_b, out_last_win_b, out_last_b, busy_b, done_b} !== 14'd0) begin
            failures++;
            $display("FAIL reset_b outputs: got %b, required 0", {mem_rd_b, mem_ch_b, mem_addr_b, out_valid_b, out_last_win_b, out_last_b, busy_b, done_b});
        end
        // start seen only while reset is high must be ignored
        start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        clear_run();
        repeat (4) tick();
        checks++;
        if (s_busy !== 1'b0 || issued != 0 || valid_seen != 0) begin
            failures++;
            $display("FAIL start_in_reset: busy=%b reads=%0d valid=%0d, required 0 0 0", s_busy, issued, valid_seen);
        end
    endtask

    task automatic test_basic();
        int seq[8];
        seq = '{0, 1, 8, 9, 2, 3, 10, 11};
        sel = 1'b0; apply_reset(); out_ready = 1'b1;
        pulse_start();
        tick();
        checks++;
        if (addr_log.size() != 1 || addr_log[0] != 0) begin
            failures++;
            $display("FAIL first_read: got %0d reads in cycle 1, required 1 read at addr 0", addr_log.size());
        end
        run_to_end(400, 1'b0);
        checks++;
        if (accepted != 192 || issued != 192) begin
            failures++;
            $display("FAIL basic_count: got %0d words %0d reads, required 192 192", accepted, issued);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (addr_log[i] != seq[i]) begin
                failures++;
                $display("FAIL addr_seq[%0d]: got %0d, required %0d", i, addr_log[i], seq[i]);
            end
        end
        checks++;
        if (first_valid_cycle != 3) begin
            failures++;
            $display("FAIL first_valid: got cycle %0d, required 3", first_valid_cycle);
        end
        checks++;
        if (last_pop_cycle != 194) begin
            failures++;
            $display("FAIL throughput: last pop cycle %0d, required 194", last_pop_cycle);
        end
        checks++;
        if (s_done !== 1'b0) begin
            failures++;
            $display("FAIL done_early: got %b in last pop cycle, required 0", s_done);
        end
        tick();
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_rise: got done=%b busy=%b, required 1 0", s_done, s_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] w0;
        w0 = exp_word(0);
        sel = 1'b0; apply_reset(); out_ready = 1'b0;
        pulse_start();
        repeat (20) tick();
        checks++;
        if (issued != 3 || o_rd !== 1'b0) begin
            failures++;
            $display("FAIL credit_stall: got %0d reads mem_rd=%b, required 3 0", issued, o_rd);
        end
        checks++;
        if (o_valid !== 1'b1 || o_data !== w0[15:0]) begin
            failures++;
            $display("FAIL hold_head: got valid=%b data=%h, required 1 %h", o_valid, o_data, w0[15:0]);
        end
        out_ready = 1'b1;
        run_to_end(400, 1'b0);
        repeat (5) tick();
        checks++;
        if (accepted != 192 || issued != 192 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d words %0d reads, required 192 192", accepted, issued);
        end
    endtask

    task automatic test_random();
        sel = 1'b1; apply_reset(); out_ready = 1'b1;
        pulse_start();
        run_to_end(3000, 1'b1);
        out_ready = 1'b1;
        checks++;
        if (accepted != 192) begin
            failures++;
            $display("FAIL rand_count: got %0d words, required 192", accepted);
        end
        checks++;
        if (max_out > 5) begin
            failures++;
            $display("FAIL rand_credit: got %0d outstanding, required <= 5", max_out);
        end
        repeat (3) tick();
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("FAIL rand_done: got %b, required 1", s_done);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sel = 1'b0; apply_reset(); out_ready = 1'b1;
        pulse_start();
        n = 0;
        while (accepted < 70 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (accepted != 70) begin
            failures++;
            $display("FAIL mid_reach: got %0d words, required 70", accepted);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({o_rd, o_ch, o_addr, o_valid, o_lw, o_last, o_busy, o_done} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset: got %b, required 0", {o_rd, o_ch, o_addr, o_valid, o_lw, o_last, o_busy, o_done});
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_run();
        repeat (10) tick();
        checks++;
        if (valid_seen != 0 || issued != 0) begin
            failures++;
            $display("FAIL post_reset_quiet: got valid=%0d reads=%0d, required 0 0", valid_seen, issued);
        end
        pulse_start();
        tick();
        checks++;
        if (addr_log.size() != 1 || addr_log[0] != 0 || o_ch !== 2'd0) begin
            failures++;
            $display("FAIL restart_addr: got %0d reads ch=%0d, required 1 read ch 0 addr 0", addr_log.size(), o_ch);
        end
        run_to_end(400, 1'b0);
        checks++;
        if (accepted != 192) begin
            failures++;
            $display("FAIL restart_count: got %0d words, required 192", accepted);
        end
    endtask

    task automatic test_start_busy();
        int n;
        sel = 1'b0; apply_reset(); out_ready = 1'b1;
        pulse_start();
        n = 0;
        while (accepted < 10 && n < 100) begin
            tick();
            n++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (s_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_start: got busy=%b, required 1", s_busy);
        end
        run_to_end(400, 1'b0);
        checks++;
        if (accepted != 192 || issued != 192) begin
            failures++;
            $display("FAIL busy_start_count: got %0d words %0d reads, required 192 192", accepted, issued);
        end
    endtask

    task automatic test_done_restart();
        repeat (3) tick();
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("FAIL in_done: got %b, required 1", s_done);
        end
        pulse_start();
        tick();
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b1 || issued != 1) begin
            failures++;
            $display("FAIL done_drop: got done=%b busy=%b reads=%0d, required 0 1 1", s_done, s_busy, issued);
        end
        run_to_end(400, 1'b0);
        tick();
        checks++;
        if (accepted != 192 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL rerun: got %0d words done=%b, required 192 1", accepted, s_done);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 1'b0;
        cycle_no = 0;
        clear_run();
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_start_busy();
        test_done_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv2_mem_read.md
Name: conv2_mem_read

Overview:
Read-side addresser/streamer for the Convolution 2 output memory. Walks the three 8x8 conv2 output feature maps in 2x2 pooling-window order and issues memory reads. It absorbs the fixed memory read latency and delivers data to the downstream pooling/FC stage over a valid/ready stream, honouring backpressure without dropping words. It runs once per start pulse and reports completion with a level done.

Parameters:
DATA_W, 16, width of one feature-map word
RD_LAT, 1, memory read latency in cycles (1..4) from mem_rd to mem_rdata valid
FIFO_DEPTH, RD_LAT+2, output buffer depth; also the read-credit limit

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  one-cycle start request; ignored unless state is IDLE or DONE
mem_rd  out  1  read enable to conv2 output memory
mem_ch  out  2  channel select (0..2)
mem_addr  out  6  pixel address within channel, row*8+col
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd
out_data  out  DATA_W  streamed word (FIFO head)
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid&&out_ready
out_last_win  out  1  qualifies out_data as 4th element of a 2x2 window
out_last  out  1  qualifies out_data as final word (ch 2, window 15, element 3)
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: mem_rd=0, mem_ch=0, mem_addr=0, out_valid=0, out_last_win=0, out_last=0, busy=0, done=0. FIFO is empty, the in-flight pipe is cleared, and state is IDLE.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE -> RUN on start. Counters are cleared and done drops on the same edge.
  - RUN -> DRAIN on the edge that issues the 192nd read.
  - DRAIN -> DONE when the in-flight count is 0 and the FIFO is empty.
  - DONE holds until start or reset.
- Traversal order (nested, outermost first):
  - ch 0..2
  - window row wr 0..3
  - window col wc 0..3
  - element e 0..3, with dy=e[1], dx=e[0]
  - mem_addr = (2*wr+dy)*8 + 2*wc+dx
  - Sequence from start: 0,1,8,9, 2,3,10,11, ..., 54,55,62,63, then the next channel.
- Credit rule:
  - A read issues (mem_rd=1) in a RUN cycle only when inflight + fifo_count < FIFO_DEPTH. Counts are taken after this cycle's pop.
  - Otherwise mem_rd=0 and the address holds.
  - This guarantees the FIFO never overflows.
- Return path:
  - The read issued in cycle t has mem_rdata sampled at the edge ending cycle t+RD_LAT and written to the FIFO.
  - out_valid is high from cycle t+RD_LAT+1.
  - Tag bits (last_win, last) travel with the in-flight pipe and are stored per FIFO entry.
- Timing with the consumer always ready: start sampled at edge 0, first mem_rd in cycle 1, first out_valid in cycle RD_LAT+2. Throughput is 1 word/cycle.
- Output stream:
  - out_data is stable while out_valid && !out_ready.
  - FIFO push and pop in the same cycle are both honoured.
- Commands:
  - start while busy is ignored.
  - start in the same cycle as reset is ignored.
- Reset mid-operation: all in-flight data is discarded and no output appears after reset deasserts.
- Widths: window and element counters are 2-bit and wrap naturally. The channel counter stops at 2 and never reaches 3.

Decomposition:
- Package conv2_rd_pkg:
  - state enum rd_state_t
  - constants IMG_W=8, N_CH=3, N_PIX=64, N_WORDS=192
  - struct rd_tag_t {last_win, last}
- Sub-module rd_skid_fifo: synchronous FIFO, parameters DEPTH and WIDTH, carrying {tag, data}. Outputs are count, empty and full; push and pop in the same cycle are allowed.

Test Plan:
- RD_LAT=1, out_ready=1, memory returns data = {ch, addr}:
  - first mem_rd in cycle 1 with addr 0
  - address sequence 0,1,8,9,2,3,10,11 at the start
  - 192 outputs on consecutive cycles
  - out_last_win on every 4th word
  - out_last only on word 191 (ch 2, addr 63)
  - done rises 1 cycle after the last pop
- out_ready=0 for 20 cycles after start:
  - exactly FIFO_DEPTH=3 reads are issued, then mem_rd stays 0
  - when ready is released, all 192 words arrive in order with none lost or duplicated
- Random out_ready (50%) with RD_LAT=3:
  - scoreboard matches the full ordered sequence
  - FIFO count never exceeds 5
- Reset asserted at word 70:
  - all outputs return to reset values asynchronously
  - no out_valid after deassertion until a new start
  - the new run restarts at ch 0, addr 0
- start pulsed again at word 10:
  - ignored, and the sequence continues uninterrupted
- start pulsed while in DONE:
  - done drops on the next edge
  - a full new 192-word run completes
